param_reg_responder: RTL

Responder end of the team's command/response register-access interface. It owns a small configuration register file, a run-time copy of a parameter package with writable `parameter` entries and read-only `localparam` entries. Accepts one read or write command at a time, waits a programmable access latency, then returns a single response beat. Sits between the configuration initiator and the datapath blocks that consume the register values.

---
 rtl/param_reg_responder.sv | 106 ++++++++++
 1 files changed

// File: rtl/param_reg_responder.sv
// param_reg_responder: command/response responder owning a parameterised register file
// with writable entries and read-only entries pinned to their reset values.
module param_reg_responder #(
    parameter int                      DATA_W     = 32,
    parameter int                      ADDR_W     = 3,
    parameter int                      NREGS      = 8,
    parameter logic [2**ADDR_W-1:0]    RO_MASK    = 8'b1100_0000,
    parameter logic [NREGS*DATA_W-1:0] RESET_VALS = '0,
    parameter int                      ACC_LAT    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rw,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [DATA_W-1:0]       cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic [NREGS*DATA_W-1:0] regs_flat,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic              r_busy;
    logic              w_mapped;
    logic              w_ro;
    logic [DATA_W-1:0] w_rd;

    assign w_mapped  = {1'b0, r_addr} < (ADDR_W+1)'(NREGS);
    assign w_ro      = RO_MASK[r_addr];
    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign busy      = r_busy;

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
    end

    // Read mux over the implemented registers; unmapped addresses yield zero
    always_comb begin
        w_rd = '0;
        for (int k = 0; k < NREGS; k++) if (r_addr == ADDR_W'(k)) w_rd = r_regs[k];
    end

    // Control FSM: latch command, count down access latency, hold response until handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            for (int k = 0; k < NREGS; k++) r_regs[k] <= RESET_VALS[k*DATA_W +: DATA_W];
        end else begin
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_rw        <= cmd_rw;
                    r_addr      <= cmd_addr;
                    r_wdata     <= cmd_wdata;
                    r_cnt       <= 4'(ACC_LAT);
                    r_cmd_ready <= 1'b0;
                    r_busy      <= 1'b1;
                    r_state     <= ACCESS;
                end
                ACCESS: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                else begin
                    if (r_rw && w_mapped && !w_ro)
                        for (int k = 0; k < NREGS; k++) if (r_addr == ADDR_W'(k)) r_regs[k] <= r_wdata;
                    r_rdata     <= (!r_rw && w_mapped) ? w_rd : '0;
                    r_err       <= !w_mapped || (r_rw && w_ro);
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_rdata     <= '0;
                    r_err       <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
